// File: rtl/rng_pkg.sv
// Shared definitions for the 5-bit pseudo-random generator and its receive-side checker.
// Generator benches reuse rng_next() so both ends agree on the sequence.
package rng_pkg;

  localparam int RNG_W = 5;
  localparam logic [RNG_W-1:0] RNG_LOCKUP = 5'b11111;
  localparam int RNG_TAP_A = 4;
  localparam int RNG_TAP_B = 2;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rng_state_e;

  // XNOR feedback keeps all-zeros legal; all-ones maps onto itself.
  function automatic logic [RNG_W-1:0] rng_next(input logic [RNG_W-1:0] q);
    return {~(q[RNG_TAP_A] ^ q[RNG_TAP_B]), q[RNG_W-1:1]};
  endfunction

endpackage

// File: rtl/rng_next_calc.sv
// Combinational successor of a generator word.
module rng_next_calc
  import rng_pkg::*;
(
  input  logic [RNG_W-1:0] q,
  output logic [RNG_W-1:0] nq
);

  assign nq = rng_next(q);

endmodule

// File: rtl/rng_checker.sv
// Receive-side sequence checker: self-synchronises a local predictor, holds lock, counts breaks.
// Optional lockup-word detection is enabled with `define RNG_CHK_LOCKUP_DET_EN.
module rng_checker
  import rng_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [RNG_W-1:0] in_data,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
`ifdef RNG_CHK_LOCKUP_DET_EN
  ,
  output logic             lockup
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  rng_state_e       state, state_d;
  logic [RNG_W-1:0] pred, pred_d, pred_next, seed_next;
  logic [MW-1:0]    match_cnt, match_d;
  logic [LW-1:0]    miss_cnt, miss_d;
  logic             err_d, inc;
  logic             hit;

  rng_next_calc u_pred_next (.q(pred),    .nq(pred_next));
  rng_next_calc u_seed_next (.q(in_data), .nq(seed_next));

  assign hit = (in_data == pred);

`ifdef RNG_CHK_LOCKUP_DET_EN
  logic lockup_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_d;
      pred      <= pred_d;
      match_cnt <= match_d;
      miss_cnt  <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_d;
    end
  end

  // Only LOCKED flywheels the predictor; HUNT and ACQUIRE reseed from the incoming word.
  always_comb begin
    state_d = state;
    pred_d  = pred;
    match_d = match_cnt;
    miss_d  = miss_cnt;
    err_d   = 1'b0;
    inc     = 1'b0;
`ifdef RNG_CHK_LOCKUP_DET_EN
    lockup_d = lockup;
`endif
    if (in_valid) begin
      case (state)
        HUNT: begin
          pred_d  = seed_next;
          match_d = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (hit) begin
            pred_d = pred_next;
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_cnt + 1'b1;
            end
          end else begin
            pred_d  = seed_next;
            match_d = '0;
          end
        end
        LOCKED: begin
          pred_d = pred_next;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            inc   = 1'b1;
            if (miss_cnt == LW'(LOSS_CNT - 1)) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
`ifdef RNG_CHK_LOCKUP_DET_EN
      // The lockup word overrides everything: it is never a seed and never counted.
      if (in_data == RNG_LOCKUP) begin
        state_d  = HUNT;
        pred_d   = pred;
        match_d  = '0;
        miss_d   = '0;
        err_d    = 1'b0;
        inc      = 1'b0;
        lockup_d = 1'b1;
      end
`endif
    end
`ifdef RNG_CHK_LOCKUP_DET_EN
    if (clear_err && !(in_valid && in_data == RNG_LOCKUP)) begin
      lockup_d = 1'b0;
    end
`endif
  end

  // Clear takes priority, so an error arriving with clear_err is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (inc && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

`ifdef RNG_CHK_LOCKUP_DET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lockup <= 1'b0;
    end else begin
      lockup <= lockup_d;
    end
  end
`endif

endmodule

// File: tb/tb_rng_checker.sv
// Directed bench for rng_checker; a second instance with a 3-bit counter exercises saturation.
module tb_rng_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_data;
  logic        clear_err;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        sat_locked, sat_pulse;
  logic [2:0]  sat_count;
`ifdef RNG_CHK_LOCKUP_DET_EN
  logic        lockup, sat_lockup;
`endif

  int checks = 0;
  int fails  = 0;
  logic [4:0] g;
  int pulses;

  always #5 clk = ~clk;

  rng_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count)
`ifdef RNG_CHK_LOCKUP_DET_EN
    , .lockup(lockup)
`endif
  );

  rng_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(sat_locked), .err_pulse(sat_pulse),
    .err_count(sat_count)
`ifdef RNG_CHK_LOCKUP_DET_EN
    , .lockup(sat_lockup)
`endif
  );

  function automatic logic [4:0] gen_next(input logic [4:0] q);
    return {~(q[4] ^ q[2]), q[4:1]};
  endfunction

  // Called at a falling edge; returns at the next falling edge with outputs updated.
  task automatic step(input logic v, input logic [4:0] d, input logic clr);
    in_valid  = v;
    in_data   = d;
    clear_err = clr;
    @(negedge clk);
    in_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic clean_word();
    step(1'b1, g, 1'b0);
    g = gen_next(g);
  endtask

  task automatic bad_word(input logic clr);
    step(1'b1, g ^ 5'h01, clr);
    g = gen_next(g);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 5'h00; clear_err = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL reset_locked got %b want 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("[TB] FAIL reset_pulse got %b want 0", err_pulse); end
    checks++; if (err_count !== 16'h0000) begin fails++; $display("[TB] FAIL reset_count got %h want 0000", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_acquire();
    logic [4:0] expect_words [5];
    expect_words = '{5'h00, 5'h10, 5'h08, 5'h14, 5'h1A};
    g = 5'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g !== expect_words[i]) begin fails++; $display("[TB] FAIL seq_word%0d got %h want %h", i, g, expect_words[i]); end
      clean_word();
      checks++;
      if (locked !== (i == 4)) begin fails++; $display("[TB] FAIL acq_locked_w%0d got %b want %b", i, locked, (i == 4)); end
    end
    pulses = 0;
    for (int i = 0; i < 95; i++) begin
      clean_word();
      if (err_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin fails++; $display("[TB] FAIL clean_pulses got %0d want 0", pulses); end
    checks++; if (err_count !== 16'h0000) begin fails++; $display("[TB] FAIL clean_count got %h want 0000", err_count); end
    checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL clean_locked got %b want 1", locked); end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 31 && g != 5'h14; i++) clean_word();
    step(1'b1, 5'h15, 1'b0);
    g = gen_next(g);
    checks++; if (err_pulse !== 1'b1) begin fails++; $display("[TB] FAIL single_pulse got %b want 1", err_pulse); end
    checks++; if (err_count !== 16'h0001) begin fails++; $display("[TB] FAIL single_count got %h want 0001", err_count); end
    checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL single_locked got %b want 1", locked); end
    checks++; if (g !== 5'h1A) begin fails++; $display("[TB] FAIL single_next_word got %h want 1a", g); end
    clean_word();
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("[TB] FAIL single_after_pulse got %b want 0", err_pulse); end
    checks++; if (err_count !== 16'h0001) begin fails++; $display("[TB] FAIL single_after_count got %h want 0001", err_count); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) step(1'b0, ~g, 1'b0);
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("[TB] FAIL idle_pulse got %b want 0", err_pulse); end
    checks++; if (err_count !== 16'h0001) begin fails++; $display("[TB] FAIL idle_count got %h want 0001", err_count); end
    checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL idle_locked got %b want 1", locked); end
    clean_word();
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("[TB] FAIL idle_resume_pulse got %b want 0", err_pulse); end
  endtask

  task automatic test_loss();
    step(1'b0, 5'h00, 1'b1);
    checks++; if (err_count !== 16'h0000) begin fails++; $display("[TB] FAIL clear_count got %h want 0000", err_count); end
    for (int i = 0; i < 3; i++) begin
      bad_word(1'b0);
      checks++; if (err_pulse !== 1'b1) begin fails++; $display("[TB] FAIL loss_pulse%0d got %b want 1", i, err_pulse); end
      checks++; if (err_count !== 16'(i + 1)) begin fails++; $display("[TB] FAIL loss_count%0d got %h want %0d", i, err_count, i + 1); end
      checks++; if (locked !== (i < 2)) begin fails++; $display("[TB] FAIL loss_locked%0d got %b want %b", i, locked, (i < 2)); end
    end
    for (int i = 0; i < 5; i++) begin
      clean_word();
      checks++; if (locked !== (i == 4)) begin fails++; $display("[TB] FAIL relock_w%0d got %b want %b", i, locked, (i == 4)); end
    end
    checks++; if (err_count !== 16'h0003) begin fails++; $display("[TB] FAIL relock_count got %h want 0003", err_count); end
  endtask

  task automatic test_gaps();
    pulse_reset();
    g = 5'h07;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      clean_word();
      if (err_pulse === 1'b1) pulses++;
      checks++; if (locked !== (k == 4)) begin fails++; $display("[TB] FAIL gap_valid%0d got %b want %b", k, locked, (k == 4)); end
      step(1'b0, g ^ 5'h0A, 1'b0);
      if (err_pulse === 1'b1) pulses++;
      checks++; if (locked !== (k == 4)) begin fails++; $display("[TB] FAIL gap_idle%0d got %b want %b", k, locked, (k == 4)); end
    end
    checks++; if (pulses != 0) begin fails++; $display("[TB] FAIL gap_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    g = 5'h00;
    for (int i = 0; i < 5; i++) clean_word();
    for (int r = 0; r < 3; r++) begin
      bad_word(1'b0);
      bad_word(1'b0);
      clean_word();
    end
    checks++; if (sat_count !== 3'd6) begin fails++; $display("[TB] FAIL sat_six got %0d want 6", sat_count); end
    bad_word(1'b0);
    checks++; if (sat_count !== 3'd7) begin fails++; $display("[TB] FAIL sat_seven got %0d want 7", sat_count); end
    clean_word();
    bad_word(1'b0);
    checks++; if (sat_count !== 3'd7) begin fails++; $display("[TB] FAIL sat_hold got %0d want 7", sat_count); end
    checks++; if (sat_pulse !== 1'b1) begin fails++; $display("[TB] FAIL sat_pulse got %b want 1", sat_pulse); end
    checks++; if (err_count !== 16'd8) begin fails++; $display("[TB] FAIL sat_main_count got %0d want 8", err_count); end
    checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL sat_locked got %b want 1", locked); end
    bad_word(1'b1);
    checks++; if (err_pulse !== 1'b1) begin fails++; $display("[TB] FAIL clrerr_pulse got %b want 1", err_pulse); end
    checks++; if (err_count !== 16'h0000) begin fails++; $display("[TB] FAIL clrerr_count got %h want 0000", err_count); end
    checks++; if (sat_count !== 3'd0) begin fails++; $display("[TB] FAIL clrerr_sat got %0d want 0", sat_count); end
    checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL clrerr_locked got %b want 1", locked); end
  endtask

  task automatic test_reset_mid();
    clean_word();
    bad_word(1'b0);
    checks++; if (err_count !== 16'h0001) begin fails++; $display("[TB] FAIL mid_pre_count got %h want 0001", err_count); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL mid_locked got %b want 0", locked); end
    checks++; if (err_count !== 16'h0000) begin fails++; $display("[TB] FAIL mid_count got %h want 0000", err_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef RNG_CHK_LOCKUP_DET_EN
  task automatic test_lockup();
    g = 5'h00;
    for (int i = 0; i < 5; i++) clean_word();
    step(1'b1, 5'h1F, 1'b0);
    checks++; if (lockup !== 1'b1) begin fails++; $display("[TB] FAIL lockup_set got %b want 1", lockup); end
    checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL lockup_locked got %b want 0", locked); end
    pulse_reset();
    checks++; if (lockup !== 1'b0) begin fails++; $display("[TB] FAIL lockup_reset got %b want 0", lockup); end
  endtask
`endif

  initial begin
    test_reset();
    test_acquire();
    test_single_error();
    test_idle();
    test_loss();
    test_gaps();
    test_saturation();
    test_reset_mid();
`ifdef RNG_CHK_LOCKUP_DET_EN
    test_lockup();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
